// File: rtl/can_feature_sequencer.sv
// CAN frame feature sequencer: captures header and data bytes into six raw features,
// issues them to the scaler, then holds until the classifier finishes. Optional WAIT
// timeout is built when FSEQ_TIMEOUT_EN is defined.
module can_feature_sequencer #(
  parameter int CLK_PER_US     = 50,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [10:0] hdr_id,
  input  logic [3:0]  hdr_dlc,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  byte_data,
  output logic        sc_valid,
  output logic [10:0] arb_id_dec,
  output logic [3:0]  data_length,
  output logic [7:0]  first_byte,
  output logic [7:0]  last_byte,
  output logic [10:0] byte_sum,
  output logic [31:0] time_delta,
  input  logic        cls_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, ISSUE, WAIT} state_t;

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  state_t        state, state_nxt;
  logic          live;
  logic [PW-1:0] presc;
  logic [31:0]   ts_us;
  logic [31:0]   prev_ts;
  logic          first_frame;
  logic [3:0]    byte_cnt;
  logic          hdr_acc, byte_acc, last_acc, expire;

  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  assign hdr_acc  = hdr_valid & hdr_ready;
  assign byte_acc = byte_valid & byte_ready;
  assign last_acc = byte_acc && ((byte_cnt + 4'd1) == data_length);

  // Microsecond timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      ts_us <= '0;
    end else if (presc == PW'(CLK_PER_US - 1)) begin
      presc <= '0;
      ts_us <= ts_us + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // live keeps hdr_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hdr_acc) state_nxt = (clamp_dlc(hdr_dlc) == 4'd0) ? ISSUE : DATA;
      DATA:    if (last_acc) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cls_done || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hdr_ready  = 1'b0;
    byte_ready = 1'b0;
    sc_valid   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        hdr_ready = live;
        busy      = 1'b0;
      end
      DATA:    byte_ready = 1'b1;
      ISSUE:   sc_valid   = 1'b1;
      default: ;
    endcase
  end

  // Feature capture: header zeroes the byte features, bytes accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_id_dec  <= '0;
      data_length <= '0;
      first_byte  <= '0;
      last_byte   <= '0;
      byte_sum    <= '0;
      time_delta  <= '0;
      prev_ts     <= '0;
      byte_cnt    <= '0;
      first_frame <= 1'b1;
    end else if (hdr_acc) begin
      arb_id_dec  <= hdr_id;
      data_length <= clamp_dlc(hdr_dlc);
      first_byte  <= '0;
      last_byte   <= '0;
      byte_sum    <= '0;
      byte_cnt    <= '0;
      time_delta  <= first_frame ? 32'd0 : (ts_us - prev_ts);
      prev_ts     <= ts_us;
      first_frame <= 1'b0;
    end else if (byte_acc) begin
      if (byte_cnt == 4'd0) first_byte <= byte_data;
      last_byte <= byte_data;
      byte_sum  <= byte_sum + {3'b000, byte_data};
      byte_cnt  <= byte_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (state == ISSUE) frame_cnt <= frame_cnt + 16'd1;
  end

`ifdef FSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // cls_done on the expiry edge takes priority over the abort
  assign expire = (state == WAIT) && !cls_done && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
      timeout_err <= expire;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_can_feature_sequencer.sv
// Bench for can_feature_sequencer: frame vector table with a scoreboard checked on
// sc_valid, plus hand sequences for timing, timeout and mid-frame reset.
module tb_can_feature_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [10:0] hdr_id = '0;
  logic [3:0]  hdr_dlc = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  byte_data = '0;
  logic        sc_valid;
  logic [10:0] arb_id_dec;
  logic [3:0]  data_length;
  logic [7:0]  first_byte, last_byte;
  logic [10:0] byte_sum;
  logic [31:0] time_delta;
  logic        cls_done = 1'b0;
  logic        busy, timeout_err;
  logic [15:0] frame_cnt;

  can_feature_sequencer #(.CLK_PER_US(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_id(hdr_id), .hdr_dlc(hdr_dlc),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .sc_valid(sc_valid), .arb_id_dec(arb_id_dec), .data_length(data_length),
    .first_byte(first_byte), .last_byte(last_byte), .byte_sum(byte_sum),
    .time_delta(time_delta), .cls_done(cls_done), .busy(busy),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    int          nofs;
    logic [7:0]  b0;
    logic [7:0]  step;
    logic [3:0]  e_len;
    logic [7:0]  e_first;
    logic [7:0]  e_last;
    logic [10:0] e_sum;
  } vec_t;

  typedef struct {
    logic [10:0] id;
    logic [3:0]  len;
    logic [7:0]  first;
    logic [7:0]  last;
    logic [10:0] sum;
    logic        chk_td;
    logic [31:0] td;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, errors = 0;
  int exp_fc = 0, sc_cnt = 0, overlap = 0, cyc = 0, acc_cyc = 0;

  logic [94:0] all_out;
  assign all_out = {hdr_ready, byte_ready, sc_valid, arb_id_dec, data_length, first_byte,
                    last_byte, byte_sum, time_delta, busy, timeout_err, frame_cnt};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (hdr_ready && byte_ready) overlap++;
    if (sc_valid) begin
      sc_cnt++;
      chk("sb_pending", (sbq.size() != 0), 1'b1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("arb_id_dec", arb_id_dec, e.id);
        chk("data_length", data_length, e.len);
        chk("first_byte", first_byte, e.first);
        chk("last_byte", last_byte, e.last);
        chk("byte_sum", byte_sum, e.sum);
        if (e.chk_td) chk("time_delta", time_delta, e.td);
      end
    end
  end

  // Returns at the negedge of the first WAIT cycle (or in IDLE if do_done).
  task automatic send_frame(input vec_t v, input logic chk_td, input logic [31:0] td,
                            input logic do_done);
    exp_t e;
    int guard, i, rdy, sc_at;
    e.id = v.id; e.len = v.e_len; e.first = v.e_first; e.last = v.e_last;
    e.sum = v.e_sum; e.chk_td = chk_td; e.td = td;
    sbq.push_back(e);
    hdr_id = v.id; hdr_dlc = v.dlc; hdr_valid = 1'b1;
    guard = 0;
    while (!hdr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("hdr_accept_bound", (guard < 50), 1'b1);
    acc_cyc = cyc + 1;
    @(negedge clk);
    hdr_valid = 1'b0;
    i = 0; rdy = 0; sc_at = -1;
    for (int c = 0; c < v.nofs + 8; c++) begin
      byte_valid = (i < v.nofs);
      byte_data  = v.b0 + 8'(i) * v.step;
      if (sc_valid) begin
        sc_at = c;
        break;
      end
      if (byte_ready) rdy++;
      if (byte_valid && byte_ready) i++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("byte_ready_cycles", rdy, v.e_len);
    chk("bytes_accepted", i, v.e_len);
    chk("sc_latency", sc_at, v.e_len);
    @(negedge clk);
    exp_fc++;
    chk("frame_cnt", frame_cnt, exp_fc[15:0]);
    chk("busy_in_wait", busy, 1'b1);
    chk("sc_single_cycle", sc_valid, 1'b0);
    if (do_done) begin
      cls_done = 1'b1;
      @(negedge clk);
      cls_done = 1'b0;
      chk("idle_after_done", hdr_ready, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hdr_valid = 1'b0; byte_valid = 1'b0; cls_done = 1'b0;
    sbq.delete();
    exp_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t va, vb, vt;
    int n, bad, a, sc_before;
    tbl[0] = '{11'h123, 4'd8,  8,  8'h01, 8'h01, 4'd8, 8'h01, 8'h08, 11'd36};
    tbl[1] = '{11'h7FF, 4'd0,  0,  8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 11'd0};
    tbl[2] = '{11'h055, 4'd12, 10, 8'hFF, 8'h00, 4'd8, 8'hFF, 8'hFF, 11'd2040};
    tbl[3] = '{11'h001, 4'd3,  3,  8'h10, 8'h10, 4'd3, 8'h10, 8'h30, 11'd96};
    tbl[4] = '{11'h400, 4'd1,  1,  8'hAA, 8'h00, 4'd1, 8'hAA, 8'hAA, 11'd170};
    tbl[5] = '{11'h2A5, 4'd9,  9,  8'hF0, 8'h01, 4'd8, 8'hF0, 8'hF7, 11'd1948};
    tbl[6] = '{11'h3C3, 4'd5,  5,  8'h80, 8'h80, 4'd5, 8'h80, 8'h80, 11'd384};
    va = '{11'h010, 4'd1, 1, 8'h5A, 8'h00, 4'd1, 8'h5A, 8'h5A, 11'd90};
    vb = '{11'h011, 4'd1, 1, 8'h07, 8'h00, 4'd1, 8'h07, 8'h07, 11'd7};
    vt = '{11'h321, 4'd0, 0, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 11'd0};

    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_out, 95'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_ready_after_reset", hdr_ready, 1'b1);
    chk("byte_ready_idle", byte_ready, 1'b0);

    for (int k = 0; k < 7; k++) send_frame(tbl[k], (k == 0), 32'd0, 1'b1);
    chk("sc_valid_count", sc_cnt, 7);
    chk("features_stable_after_done", byte_sum, 11'd384);

    // cls_done in IDLE must not disturb anything
    cls_done = 1'b1;
    @(negedge clk);
    cls_done = 1'b0;
    chk("cls_done_idle_ignored", {hdr_ready, busy}, 2'b10);

    // Headers exactly 1000 clocks apart at 4 clocks per microsecond
    do_reset();
    send_frame(va, 1'b1, 32'd0, 1'b1);
    a = acc_cyc;
    while (cyc + 1 < a + 1000) @(negedge clk);
    send_frame(vb, 1'b1, 32'd250, 1'b1);
    chk("hdr_gap_cycles", acc_cyc - a, 1000);

    // No cls_done in WAIT
    send_frame(vt, 1'b0, 32'd0, 1'b0);
`ifdef FSEQ_TIMEOUT_EN
    n = 1;
    while (busy && n < 40) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("timeout_wait_cycles", n, 16);
    chk("timeout_err_pulse", timeout_err, 1'b1);
    chk("hdr_ready_after_timeout", hdr_ready, 1'b1);
    @(negedge clk);
    chk("timeout_err_one_cycle", timeout_err, 1'b0);
    chk("frame_cnt_kept", frame_cnt, exp_fc[15:0]);
    send_frame(vt, 1'b0, 32'd0, 1'b0);
    repeat (15) @(negedge clk);
    cls_done = 1'b1;
    @(negedge clk);
    cls_done = 1'b0;
    chk("done_at_expiry_no_err", timeout_err, 1'b0);
    chk("done_at_expiry_idle", hdr_ready, 1'b1);
`else
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (!busy || timeout_err) bad++;
    end
    chk("busy_held_no_timeout", bad, 0);
    cls_done = 1'b1;
    @(negedge clk);
    cls_done = 1'b0;
    chk("idle_after_late_done", hdr_ready, 1'b1);
`endif

    // cls_done on the third WAIT cycle
    send_frame(vt, 1'b0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    cls_done = 1'b1;
    @(negedge clk);
    cls_done = 1'b0;
    chk("done_after_3_idle", hdr_ready, 1'b1);
    chk("done_after_3_no_err", timeout_err, 1'b0);

    // Reset during DATA after 3 of 8 bytes
    do_reset();
    hdr_id = 11'h155; hdr_dlc = 4'd8; hdr_valid = 1'b1;
    @(negedge clk);
    hdr_valid = 1'b0;
    byte_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      byte_data = 8'(b + 1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("partial_sum_before_reset", byte_sum, 11'd6);
    sc_before = sc_cnt;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_frame_outputs", all_out, 95'd0);
    sbq.delete();
    exp_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_sc_after_abort", sc_cnt, sc_before);
    send_frame(tbl[0], 1'b1, 32'd0, 1'b1);
    chk("frame_cnt_after_reset", frame_cnt, 16'd1);

    chk("ready_overlap", overlap, 0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
